if_id_ctrl: RTL and testbench
=============================

// Module: if_id_ctrl
// PURPOSE
// - Consumer/controller end of the IF stage interface: owns the IF->ID pipeline register and drives IF's
//   control inputs (IFWrite, IF_flush, Branch, Jump, JumpAddr).
// - Detects load-use hazards, resolves JAL in ID, and accepts branch/JALR redirects from EX.
// - Sits between the IF instance and the ID stage in Risc5CPU; also sources the Instruction_id, JumpFlag
//   and Stall top-level outputs.
// PARAMETERS
// - XLEN   32            datapath / PC width
// - NOP    32'h00000013  bubble instruction (addi x0,x0,0)
// - CNT_W  32            width of the stall and flush performance counters
// PORTS
// - clk               in   1      single clock, rising edge
// - reset             in   1      synchronous, active-high
// - PC_if             in   XLEN   PC of the instruction in IF
// - Instruction_if    in   32     fetched instruction
// - ex_MemRead        in   1      instruction in EX is a load
// - ex_rd             in   5      destination register of the instruction in EX
// - ex_redirect       in   1      taken branch or JALR resolved in EX
// - ex_target         in   XLEN   redirect target from EX
// - IFWrite           out  1      PC/IF write enable
// - IF_flush          out  1      squash the instruction currently in IF
// - Branch            out  1      EX redirect select
// - Jump              out  1      ID JAL redirect select
// - JumpAddr          out  XLEN   redirect target to IF
// - PC_id             out  XLEN   IF/ID register: PC
// - Instruction_id    out  32     IF/ID register: instruction
// - Stall             out  1      insert a bubble into ID/EX this cycle
// - JumpFlag          out  2      00 none, 01 ID JAL, 10 EX redirect, 11 reserved (never driven)
// - stall_cnt         out  CNT_W  count of cycles with Stall=1
// - flush_cnt         out  CNT_W  count of cycles with IF_flush=1
// BEHAVIOUR
// - Reset (sync): PC_id=0, Instruction_id=NOP, counters=0.
// - Combinational outputs (IFWrite, IF_flush, Branch, Jump, JumpAddr, Stall, JumpFlag) are derived from
//   the post-reset register state while reset is asserted.
// - Decode from Instruction_id: rs1=[19:15], rs2=[24:20], opc=[6:0].
//   - rs1 is used unless opc is LUI 0110111, AUIPC 0010111 or JAL 1101111.
//   - rs2 is used for opc R 0110011, S 0100011 and B 1100011.
// - load_use = ex_MemRead & ex_rd!=0 & ((rs1 used & rs1==ex_rd) | (rs2 used & rs2==ex_rd)).
// - id_jal = (opc==1101111).
// - Priority, evaluated combinationally each cycle:
//   1. ex_redirect: Branch=1, JumpAddr=ex_target, IF_flush=1, IFWrite=1, Stall=0, JumpFlag=10.
//      Next edge: Instruction_id<=NOP, PC_id<=0 (ID holds wrong-path work).
//   2. load_use: Stall=1, IFWrite=0, IF_flush=0, JumpFlag=00. IF/ID holds its value.
//      Exactly 1 stall cycle per load-use, because the load leaves EX.
//   3. id_jal: Jump=1, JumpAddr=PC_id + sext({I[31],I[19:12],I[20],I[30:21],1'b0}), IF_flush=1,
//      IFWrite=1, JumpFlag=01. Next edge: Instruction_id<=NOP. The JAL itself proceeds to EX.
//   4. Otherwise IFWrite=1 and all other controls are 0.
//      Next edge: PC_id<=PC_if, Instruction_id<=Instruction_if.
// - Branch and Jump are never both 1. When neither is 1, JumpAddr=0.
// - Target add wraps modulo 2^XLEN; no alignment check.
// - Redirect cost: JAL 1 bubble, EX redirect 2 bubbles.
// - Counters: stall_cnt++ when Stall=1; flush_cnt++ when IF_flush=1. Both wrap at 2^CNT_W.
// - ex_redirect during a load_use cancels the stall (priority 1) and stall_cnt does not increment.
// - Reset asserted mid-stall or mid-redirect: the next edge restores the reset state unconditionally.
// STRUCTURE
// - risc5_pkg holds the opcode localparams, the NOP constant and the JumpFlag encodings
//   (JF_NONE / JF_ID / JF_EX).
// - Sub-module hazard_detect (combinational): Instruction_id, ex_MemRead, ex_rd -> load_use.
// - Everything else (IF/ID register, priority mux, counters) lives in this module.
// TESTING
// 1. Reset: hold reset 2 cycles, then release.
//    -> Instruction_id=32'h00000013, PC_id=0, IFWrite=1, JumpFlag=00, stall_cnt=0.
// 2. Load-use: ID holds add x3,x5,x6 while EX has a load with ex_rd=5.
//    -> Stall=1, IFWrite=0 for exactly 1 cycle; IF/ID unchanged; stall_cnt=1.
//    Repeat with ex_rd=0 -> no stall.
// 3. JAL: PC_id=0x100, Instruction_id=jal x1,+0x20.
//    -> Jump=1, JumpAddr=0x120, IF_flush=1, JumpFlag=01; next cycle Instruction_id=NOP.
// 4. EX redirect: ex_redirect=1, ex_target=0x200 while ID holds a valid op.
//    -> Branch=1, JumpAddr=0x200, JumpFlag=10; next cycle Instruction_id=NOP; flush_cnt increments.
// 5. Simultaneous: ex_redirect=1 coincident with load_use and with a JAL in ID.
//    -> EX redirect wins: Stall=0, Jump=0, JumpAddr=ex_target.
// 6. Counter wrap (CNT_W=4): 16 consecutive stall events -> stall_cnt returns to 0.
//    Assert reset mid-stall -> state cleared on the next edge.

Source files
------------

// File: rtl/risc5_pkg.sv
// Shared decode constants for the IF/ID controller: opcodes, the bubble
// instruction, JumpFlag encodings and the JAL immediate helper.
package risc5_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // addi x0,x0,0 -- the bubble placed into ID when it is squashed
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    JF_NONE = 2'b00,
    JF_ID   = 2'b01,
    JF_EX   = 2'b10
  } jump_flag_e;

  // Reassemble the 21-bit J-type offset (bit 0 always zero) from instr[31:12].
  function automatic logic [20:0] jal_imm(input logic [31:12] hi);
    return {hi[31], hi[19:12], hi[20], hi[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/if_id_ctrl_hazard_detect.sv
// Load-use detector: flags when the instruction in ID reads the register a
// load currently in EX is about to write.
module hazard_detect
  import risc5_pkg::*;
(
  input  logic [6:0] i_opc,
  input  logic [4:0] i_rs1,
  input  logic [4:0] i_rs2,
  input  logic       i_ex_mem_read,
  input  logic [4:0] i_ex_rd,
  output logic       o_load_use
);

  logic w_rs1_used;
  logic w_rs2_used;

  // Source-operand usage by opcode; the load result can only hit a real read.
  always_comb begin
    w_rs1_used = !((i_opc == OPC_LUI) || (i_opc == OPC_AUIPC) || (i_opc == OPC_JAL));
    w_rs2_used = (i_opc == OPC_OP) || (i_opc == OPC_STORE) || (i_opc == OPC_BRANCH);
    o_load_use = i_ex_mem_read && (i_ex_rd != 5'd0) &&
                 ((w_rs1_used && (i_rs1 == i_ex_rd)) ||
                  (w_rs2_used && (i_rs2 == i_ex_rd)));
  end

endmodule

// File: rtl/if_id_ctrl.sv
// IF/ID pipeline register plus the controller driving IF: load-use stall,
// JAL resolution in ID, EX redirects, and stall/flush performance counters.
module if_id_ctrl
  import risc5_pkg::*;
#(
  parameter int          XLEN  = 32,
  parameter logic [31:0] NOP   = NOP_INSTR,
  parameter int          CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  PC_if,
  input  logic [31:0]      Instruction_if,
  input  logic             ex_MemRead,
  input  logic [4:0]       ex_rd,
  input  logic             ex_redirect,
  input  logic [XLEN-1:0]  ex_target,
  output logic             IFWrite,
  output logic             IF_flush,
  output logic             Branch,
  output logic             Jump,
  output logic [XLEN-1:0]  JumpAddr,
  output logic [XLEN-1:0]  PC_id,
  output logic [31:0]      Instruction_id,
  output logic             Stall,
  output logic [1:0]       JumpFlag,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [XLEN-1:0]  r_pc_id;
  logic [31:0]      r_instr_id;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic             w_load_use;
  logic             w_id_jal;
  logic [20:0]      w_jal_imm;
  logic [XLEN-1:0]  w_jal_target;

  assign w_id_jal     = (r_instr_id[6:0] == OPC_JAL);
  assign w_jal_imm    = jal_imm(r_instr_id[31:12]);
  // Sign-extended offset; the add wraps naturally at XLEN bits.
  assign w_jal_target = r_pc_id + {{(XLEN-21){w_jal_imm[20]}}, w_jal_imm};

  hazard_detect u_hazard_detect (
    .i_opc         (r_instr_id[6:0]),
    .i_rs1         (r_instr_id[19:15]),
    .i_rs2         (r_instr_id[24:20]),
    .i_ex_mem_read (ex_MemRead),
    .i_ex_rd       (ex_rd),
    .o_load_use    (w_load_use)
  );

  // Priority mux: EX redirect, then load-use stall, then JAL in ID, else run.
  always_comb begin
    IFWrite  = 1'b1;
    IF_flush = 1'b0;
    Branch   = 1'b0;
    Jump     = 1'b0;
    JumpAddr = '0;
    Stall    = 1'b0;
    JumpFlag = JF_NONE;
    if (ex_redirect) begin
      Branch   = 1'b1;
      JumpAddr = ex_target;
      IF_flush = 1'b1;
      JumpFlag = JF_EX;
    end else if (w_load_use) begin
      Stall   = 1'b1;
      IFWrite = 1'b0;
    end else if (w_id_jal) begin
      Jump     = 1'b1;
      JumpAddr = w_jal_target;
      IF_flush = 1'b1;
      JumpFlag = JF_ID;
    end
  end

  // IF/ID register: squash on redirect, hold on stall, bubble behind a JAL.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc_id    <= '0;
      r_instr_id <= NOP;
    end else if (ex_redirect) begin
      r_pc_id    <= '0;
      r_instr_id <= NOP;
    end else if (w_load_use) begin
      r_pc_id    <= r_pc_id;
      r_instr_id <= r_instr_id;
    end else if (w_id_jal) begin
      // The fetched slot is dead; the PC still advances but is paired with a NOP.
      r_pc_id    <= PC_if;
      r_instr_id <= NOP;
    end else begin
      r_pc_id    <= PC_if;
      r_instr_id <= Instruction_if;
    end
  end

  // Performance counters, free-running and wrapping at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(Stall);
      r_flush_cnt <= r_flush_cnt + CNT_W'(IF_flush);
    end
  end

  assign PC_id          = r_pc_id;
  assign Instruction_id = r_instr_id;
  assign stall_cnt      = r_stall_cnt;
  assign flush_cnt      = r_flush_cnt;

endmodule

// File: tb/tb_if_id_ctrl.sv
// Randomized and directed bench for if_id_ctrl against a behavioural model.
module tb_if_id_ctrl;

  localparam int          XLEN  = 32;
  localparam int          CNT_W = 4;
  localparam logic [31:0] NOPI  = 32'h00000013;
  localparam logic [31:0] ADD_X3_X5_X6 = 32'h006281B3;
  localparam logic [31:0] JAL_X1_P20   = 32'h020000EF;

  logic             clk = 1'b0;
  logic             reset;
  logic [XLEN-1:0]  PC_if;
  logic [31:0]      Instruction_if;
  logic             ex_MemRead;
  logic [4:0]       ex_rd;
  logic             ex_redirect;
  logic [XLEN-1:0]  ex_target;
  logic             IFWrite, IF_flush, Branch, Jump, Stall;
  logic [XLEN-1:0]  JumpAddr, PC_id;
  logic [31:0]      Instruction_id;
  logic [1:0]       JumpFlag;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  if_id_ctrl #(.XLEN(XLEN), .NOP(NOPI), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .PC_if(PC_if), .Instruction_if(Instruction_if),
    .ex_MemRead(ex_MemRead), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
    .ex_target(ex_target), .IFWrite(IFWrite), .IF_flush(IF_flush),
    .Branch(Branch), .Jump(Jump), .JumpAddr(JumpAddr), .PC_id(PC_id),
    .Instruction_id(Instruction_id), .Stall(Stall), .JumpFlag(JumpFlag),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference state: what ID holds and how many events have been seen.
  logic [31:0] m_pc, m_instr;
  int unsigned m_scnt, m_fcnt;
  // Expected control outputs for the current cycle.
  logic        e_ifw, e_flush, e_br, e_jmp, e_stall;
  logic [31:0] e_addr;
  logic [1:0]  e_jf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // JAL target from the textbook J-type layout, using signed integer math.
  function automatic logic [31:0] jal_target(input logic [31:0] pc, input logic [31:0] ins);
    int off;
    off = 0;
    if (ins[31]) off = -(1 << 20);
    off = off + (int'(ins[19:12]) << 12);
    off = off + (int'(ins[20]) << 11);
    off = off + (int'(ins[30:21]) << 1);
    return pc + 32'(off);
  endfunction

  task automatic model_comb();
    logic [6:0] opc;
    logic [4:0] rs1, rs2;
    logic       reads1, reads2, lu, jal;
    opc    = m_instr[6:0];
    rs1    = m_instr[19:15];
    rs2    = m_instr[24:20];
    reads1 = !(opc == 7'h37 || opc == 7'h17 || opc == 7'h6F);
    reads2 = (opc == 7'h33 || opc == 7'h23 || opc == 7'h63);
    lu     = ex_MemRead && (ex_rd != 0) &&
             ((reads1 && rs1 == ex_rd) || (reads2 && rs2 == ex_rd));
    jal    = (opc == 7'h6F);
    e_ifw = 1; e_flush = 0; e_br = 0; e_jmp = 0; e_stall = 0; e_addr = 0; e_jf = 2'd0;
    if (ex_redirect) begin
      e_br = 1; e_flush = 1; e_addr = ex_target; e_jf = 2'd2;
    end else if (lu) begin
      e_stall = 1; e_ifw = 0;
    end else if (jal) begin
      e_jmp = 1; e_flush = 1; e_addr = jal_target(m_pc, m_instr); e_jf = 2'd1;
    end
  endtask

  // Drive one cycle's inputs, let them settle, compare everything to the model.
  task automatic apply(input logic rst, input logic [31:0] pcif, input logic [31:0] ins,
                       input logic mr, input logic [4:0] rd, input logic red,
                       input logic [31:0] tgt);
    reset = rst; PC_if = pcif; Instruction_if = ins;
    ex_MemRead = mr; ex_rd = rd; ex_redirect = red; ex_target = tgt;
    #1;
    model_comb();
    check("IFWrite",        32'(IFWrite),   32'(e_ifw));
    check("IF_flush",       32'(IF_flush),  32'(e_flush));
    check("Branch",         32'(Branch),    32'(e_br));
    check("Jump",           32'(Jump),      32'(e_jmp));
    check("Stall",          32'(Stall),     32'(e_stall));
    check("JumpAddr",       JumpAddr,       e_addr);
    check("JumpFlag",       32'(JumpFlag),  32'(e_jf));
    check("PC_id",          PC_id,          m_pc);
    check("Instruction_id", Instruction_id, m_instr);
    check("stall_cnt",      32'(stall_cnt), m_scnt);
    check("flush_cnt",      32'(flush_cnt), m_fcnt);
    $display("[TB] cyc %0d rst=%b red=%b mr=%b rd=%0d pc_id=%h ins_id=%h stall=%b flush=%b jf=%0d",
             cyc, rst, red, mr, rd, PC_id, Instruction_id, Stall, IF_flush, JumpFlag);
  endtask

  // Clock edge: advance the reference with the inputs held from apply().
  task automatic tick();
    logic lu;
    model_comb();
    lu = e_stall;
    @(posedge clk);
    if (reset) begin
      m_pc = 0; m_instr = NOPI; m_scnt = 0; m_fcnt = 0;
    end else begin
      if (e_stall) m_scnt = (m_scnt + 1) % 16;
      if (e_flush) m_fcnt = (m_fcnt + 1) % 16;
      if (ex_redirect) begin
        m_pc = 0; m_instr = NOPI;
      end else if (lu) begin
        // ID holds
      end else if (e_jmp) begin
        m_pc = PC_if; m_instr = NOPI;
      end else begin
        m_pc = PC_if; m_instr = Instruction_if;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [6:0]  opcs [8];
    opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
    ins        = $urandom;
    ins[6:0]   = opcs[$urandom_range(0, 7)];
    ins[19:15] = 5'($urandom_range(0, 7));
    ins[24:20] = 5'($urandom_range(0, 7));
    return ins;
  endfunction

  initial begin
    int unsigned f0;
    reset = 1; PC_if = 0; Instruction_if = NOPI;
    ex_MemRead = 0; ex_rd = 0; ex_redirect = 0; ex_target = 0;
    m_pc = 0; m_instr = NOPI; m_scnt = 0; m_fcnt = 0;
    @(negedge clk);
    @(negedge clk);

    // 1. Reset held two cycles, then released.
    apply(1, 32'h0, NOPI, 0, 0, 0, 0); tick();
    apply(1, 32'h0, NOPI, 0, 0, 0, 0); tick();
    apply(0, 32'h4, NOPI, 0, 0, 0, 0);
    check("rst_instr", Instruction_id, NOPI);
    check("rst_pc",    PC_id, 32'h0);
    check("rst_ifw",   32'(IFWrite), 32'h1);
    check("rst_jf",    32'(JumpFlag), 32'h0);
    check("rst_scnt",  32'(stall_cnt), 32'h0);
    tick();

    // 2. Load-use on add x3,x5,x6 with a load to x5 in EX; then ex_rd=0.
    apply(0, 32'h40, ADD_X3_X5_X6, 0, 0, 0, 0); tick();
    apply(0, 32'h44, NOPI, 1, 5, 0, 0);
    check("lu_stall", 32'(Stall), 32'h1);
    check("lu_ifw",   32'(IFWrite), 32'h0);
    tick();
    apply(0, 32'h44, NOPI, 0, 0, 0, 0);
    check("lu_hold",  Instruction_id, ADD_X3_X5_X6);
    check("lu_scnt",  32'(stall_cnt), 32'h1);
    check("lu_once",  32'(Stall), 32'h0);
    tick();
    apply(0, 32'h50, ADD_X3_X5_X6, 0, 0, 0, 0); tick();
    apply(0, 32'h54, NOPI, 1, 0, 0, 0);
    check("x0_nostall", 32'(Stall), 32'h0);
    tick();

    // 3. JAL x1,+0x20 at PC 0x100.
    apply(0, 32'h100, JAL_X1_P20, 0, 0, 0, 0); tick();
    apply(0, 32'h104, ADD_X3_X5_X6, 0, 0, 0, 0);
    check("jal_jump",  32'(Jump), 32'h1);
    check("jal_addr",  JumpAddr, 32'h120);
    check("jal_flush", 32'(IF_flush), 32'h1);
    check("jal_jf",    32'(JumpFlag), 32'h1);
    tick();
    apply(0, 32'h120, NOPI, 0, 0, 0, 0);
    check("jal_bubble", Instruction_id, NOPI);
    tick();

    // 4. EX redirect to 0x200 while ID holds a valid op.
    apply(0, 32'h60, ADD_X3_X5_X6, 0, 0, 0, 0); tick();
    f0 = m_fcnt;
    apply(0, 32'h64, NOPI, 0, 0, 1, 32'h200);
    check("red_branch", 32'(Branch), 32'h1);
    check("red_addr",   JumpAddr, 32'h200);
    check("red_jf",     32'(JumpFlag), 32'h2);
    tick();
    apply(0, 32'h200, NOPI, 0, 0, 0, 0);
    check("red_bubble", Instruction_id, NOPI);
    check("red_fcnt",   32'(flush_cnt), (f0 + 1) % 16);
    tick();

    // 5. Redirect coinciding with a load-use, then with a JAL in ID.
    apply(0, 32'h70, ADD_X3_X5_X6, 0, 0, 0, 0); tick();
    f0 = m_scnt;
    apply(0, 32'h74, NOPI, 1, 6, 1, 32'h300);
    check("sim_lu_stall", 32'(Stall), 32'h0);
    check("sim_lu_addr",  JumpAddr, 32'h300);
    tick();
    apply(0, 32'h300, NOPI, 0, 0, 0, 0);
    check("sim_lu_scnt", 32'(stall_cnt), f0);
    tick();
    apply(0, 32'h100, JAL_X1_P20, 0, 0, 0, 0); tick();
    apply(0, 32'h104, NOPI, 0, 0, 1, 32'h400);
    check("sim_jal_jump", 32'(Jump), 32'h0);
    check("sim_jal_addr", JumpAddr, 32'h400);
    tick();

    // 6. Counter wrap after 16 stalls, then reset asserted mid-stall.
    apply(1, 32'h0, NOPI, 0, 0, 0, 0); tick();
    apply(0, 32'h80, ADD_X3_X5_X6, 0, 0, 0, 0); tick();
    for (int i = 0; i < 16; i++) begin
      apply(0, 32'h84, NOPI, 1, 5, 0, 0); tick();
    end
    apply(0, 32'h84, NOPI, 0, 0, 0, 0);
    check("wrap_scnt", 32'(stall_cnt), 32'h0);
    tick();
    apply(0, 32'h90, ADD_X3_X5_X6, 0, 0, 0, 0); tick();
    apply(0, 32'h94, NOPI, 1, 6, 0, 0); tick();
    apply(1, 32'h94, NOPI, 1, 6, 0, 0); tick();
    apply(0, 32'h0, NOPI, 0, 0, 0, 0);
    check("rst_mid_instr", Instruction_id, NOPI);
    check("rst_mid_scnt",  32'(stall_cnt), 32'h0);
    tick();
    apply(0, 32'h10, ADD_X3_X5_X6, 0, 0, 0, 0); tick();
    apply(1, 32'h14, NOPI, 0, 0, 1, 32'h500); tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(0, 49) == 0), $urandom & 32'hFFFF_FFFC, rand_instr(),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            ($urandom_range(0, 6) == 0), $urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
